dut_bus_initiator: RTL and testbench

//  Initiator for the dut read/write interface: accepts one command at a time on a

---
 rtl/dut_bus_initiator.sv | 143 ++++++++++++++
 tb/tb_dut_bus_initiator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_bus_initiator.sv
// Bus initiator for the dut read/write interface: one command in flight, issued as a
// single-cycle rdy-gated enable pulse, read data captured RD_LAT cycles later.
module dut_bus_initiator #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 1,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic              read_rdy,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic              busy
);

  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [2:0]      LAT     = 3'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RSP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [2:0]        r_cnt;
  logic [TO_W-1:0]   r_wait;
  logic              w_rdy;
  logic              w_timeout;

  // The wait counter only ever counts stalled cycles of the current command.
  assign w_rdy     = (r_state == S_WR) ? write_rdy : read_rdy;
  assign w_timeout = (TIMEOUT != 0) && !w_rdy && (r_wait == TO_LAST);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    write_en = 1'b0;
    read_en  = 1'b0;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = cmd_write ? S_WR : S_RD;
      S_WR: begin
        if (write_rdy) begin
          write_en = 1'b1;
          w_next   = S_RSP;
        end else if (w_timeout) begin
          w_next = S_RSP;
        end
      end
      S_RD: begin
        if (read_rdy) begin
          read_en = 1'b1;
          w_next  = (RD_LAT == 0) ? S_RSP : S_RD_WAIT;
        end else if (w_timeout) begin
          w_next = S_RSP;
        end
      end
      S_RD_WAIT: if (r_cnt == 3'd1) w_next = S_RSP;
      S_RSP:     if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rsp_valid     = (r_state == S_RSP);
  assign rsp_write     = r_write;
  assign rsp_addr      = r_addr;
  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;
  assign write_address = (r_state == S_WR) ? r_addr  : '0;
  assign write_data    = (r_state == S_WR) ? r_wdata : '0;
  assign read_address  = (r_state == S_RD) ? r_addr  : '0;

  // NOTE: state registers use non-blocking assignments and clear asynchronously on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_write ? cmd_wdata : '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_wait  <= '0;
          end
        end
        S_WR, S_RD: begin
          if (r_state == S_RD && read_rdy) begin
            r_cnt <= LAT;
            if (RD_LAT == 0) r_rdata <= read_data;
          end else if (!w_rdy) begin
            r_wait <= r_wait + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_rdata <= read_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_bus_initiator.sv
// Bench for dut_bus_initiator: transaction-level reference model plus a responder with a
// 2-stage read pipeline; directed scenarios followed by randomized traffic.
module tb_dut_bus_initiator;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 1;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 16;

  logic              CLK, RST;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] read_address, write_address;
  logic              read_en, read_rdy, write_en, write_rdy, busy;
  logic [DATA_W-1:0] read_data, write_data;

  dut_bus_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) u_dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .read_address(read_address), .read_en(read_en), .read_rdy(read_rdy), .read_data(read_data),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Stimulus knobs applied at each falling edge.
  logic              k_rst, k_cmd_valid, k_cmd_write, k_wrdy, k_rrdy, k_rsp_ready;
  logic [ADDR_W-1:0] k_cmd_addr;
  logic [DATA_W-1:0] k_cmd_wdata;

  // Responder: storage plus a read pipeline of depth RD_LAT, junk when idle.
  logic [DATA_W-1:0] rmem [8];
  logic [DATA_W-1:0] pipe [RD_LAT];

  // Reference model: one outstanding command, resolved when its rdy first rises
  // or after TIMEOUT stalled cycles; response visible from m_rsp_cyc onwards.
  bit                m_pend, m_resolved, m_write, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  int                m_low, m_rsp_cyc;
  logic [DATA_W-1:0] mmem [8];

  // Observations for the directed checks.
  int   obs_acc, obs_rsp, wen_cnt, ren_cnt, rsp_cnt;
  logic obs_err, obs_write;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_rdata;
  logic prev_rsp_valid;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_fields"}, {rsp_write, rsp_addr, rsp_rdata, rsp_err}, 0);
    check({tag, "_en"}, {read_en, write_en}, 0);
    check({tag, "_bus"}, {read_address, write_address, write_data}, 0);
  endtask

  task automatic step();
    logic rdy;
    @(negedge CLK);
    RST       = k_rst;
    cmd_valid = k_cmd_valid;
    cmd_write = k_cmd_write;
    cmd_addr  = k_cmd_addr;
    cmd_wdata = k_cmd_wdata;
    write_rdy = k_wrdy;
    read_rdy  = k_rrdy;
    rsp_ready = k_rsp_ready;
    read_data = pipe[RD_LAT-1];
    #1;
    if (RST) begin
      check_reset_outputs("rst");
      m_pend = 0;
    end else begin
      if (!m_pend) begin
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_en", {read_en, write_en}, 0);
        check("idle_bus", {read_address, write_address, write_data}, 0);
      end else begin
        check("busy_ready", cmd_ready, 0);
        check("busy_busy", busy, 1);
        if (!m_resolved) begin
          check("issue_rsp_valid", rsp_valid, 0);
          check("issue_wen", write_en, m_write ? k_wrdy : 1'b0);
          check("issue_ren", read_en, m_write ? 1'b0 : k_rrdy);
          if (m_write && k_wrdy) check("issue_wbus", {write_address, write_data}, {m_addr, m_wdata});
          if (!m_write && k_rrdy) check("issue_raddr", read_address, m_addr);
        end else begin
          check("post_en", {read_en, write_en}, 0);
          if (cyc < m_rsp_cyc) begin
            check("wait_rsp_valid", rsp_valid, 0);
          end else begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_fields", {rsp_write, rsp_addr, rsp_rdata, rsp_err},
                  {m_write, m_addr, m_rdata, m_err});
          end
        end
      end
      // Model advance across the coming rising edge.
      if (m_pend && !m_resolved) begin
        rdy = m_write ? k_wrdy : k_rrdy;
        if (rdy) begin
          m_resolved = 1;
          m_err      = 0;
          if (m_write) begin
            mmem[m_addr] = m_wdata;
            m_rdata      = '0;
            m_rsp_cyc    = cyc + 1;
          end else begin
            m_rdata   = mmem[m_addr];
            m_rsp_cyc = cyc + 1 + RD_LAT;
          end
        end else begin
          m_low++;
          if (TIMEOUT != 0 && m_low == TIMEOUT) begin
            m_resolved = 1;
            m_err      = 1;
            m_rdata    = '0;
            m_rsp_cyc  = cyc + 1;
          end
        end
      end else if (m_pend && cyc >= m_rsp_cyc && k_rsp_ready) begin
        m_pend = 0;
      end else if (!m_pend && k_cmd_valid) begin
        m_pend     = 1;
        m_resolved = 0;
        m_write    = k_cmd_write;
        m_addr     = k_cmd_addr;
        m_wdata    = k_cmd_write ? k_cmd_wdata : '0;
        m_low      = 0;
      end
      if (cmd_valid && cmd_ready) obs_acc = cyc;
    end
    if (rsp_valid && !prev_rsp_valid) obs_rsp = cyc;
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      obs_err   = rsp_err;
      obs_write = rsp_write;
      obs_addr  = rsp_addr;
      obs_rdata = rsp_rdata;
    end
    prev_rsp_valid = rsp_valid;
    wen_cnt += int'(write_en);
    ren_cnt += int'(read_en);
    if (write_en) rmem[write_address] = write_data;
    for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = read_en ? rmem[read_address] : DATA_W'($urandom);
    cyc++;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int  c0;
    bit  done;
    c0   = rsp_cnt;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rsp_cnt != c0) begin
        done = 1;
        break;
      end
    end
    check({tag, "_completed"}, done, 1);
  endtask

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    k_cmd_valid = 1; k_cmd_write = wr; k_cmd_addr = a; k_cmd_wdata = d;
    step();
    k_cmd_valid = 0;
  endtask

  initial begin
    int w0, r0, c0, stall;
    RST = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; read_rdy = 0; write_rdy = 0; read_data = '0;
    k_rst = 1; k_cmd_valid = 0; k_cmd_write = 0; k_cmd_addr = '0; k_cmd_wdata = '0;
    k_wrdy = 1; k_rrdy = 1; k_rsp_ready = 1;
    m_pend = 0; m_resolved = 0; m_write = 0; m_err = 0; m_addr = '0; m_wdata = '0;
    m_rdata = '0; m_low = 0; m_rsp_cyc = 0;
    obs_acc = 0; obs_rsp = 0; wen_cnt = 0; ren_cnt = 0; rsp_cnt = 0;
    obs_err = 0; obs_write = 0; obs_addr = '0; obs_rdata = '0; prev_rsp_valid = 0;
    for (int i = 0; i < 8; i++) begin
      rmem[i] = DATA_W'($urandom);
      mmem[i] = rmem[i];
    end
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;

    #1;
    check_reset_outputs("por");
    repeat (3) step();
    k_rst = 0;
    step();

    // 1: write addr 5 data 1, response two cycles after accept.
    w0 = wen_cnt;
    issue(1, 3'd5, 1'b1);
    wait_done(20, "t1");
    check("t1_latency", obs_rsp - obs_acc, 2);
    check("t1_wen_pulses", wen_cnt - w0, 1);
    check("t1_err", obs_err, 0);

    // 2: read back addr 5 through the 2-stage pipe.
    issue(0, 3'd5, 1'b0);
    wait_done(20, "t2");
    check("t2_rdata", obs_rdata, 1);
    check("t2_addr", obs_addr, 5);
    check("t2_latency", obs_rsp - obs_acc, 4);

    // 3: write_rdy held low 10 cycles, then exactly one pulse.
    k_wrdy = 0;
    w0 = wen_cnt;
    issue(1, 3'd2, 1'b1);
    repeat (10) step();
    check("t3_no_pulse_while_low", wen_cnt - w0, 0);
    k_wrdy = 1;
    wait_done(20, "t3");
    check("t3_one_pulse", wen_cnt - w0, 1);
    check("t3_err", obs_err, 0);

    // 4: read_rdy stuck low -> timeout error, no read_en.
    k_rrdy = 0;
    r0 = ren_cnt;
    issue(0, 3'd6, 1'b0);
    wait_done(40, "t4");
    check("t4_err", obs_err, 1);
    check("t4_latency", obs_rsp - obs_acc, TIMEOUT + 1);
    check("t4_no_ren", ren_cnt - r0, 0);
    check("t4_rdata", obs_rdata, 0);
    k_rrdy = 1;

    // 5: response held by rsp_ready=0 for 5 cycles; new commands are ignored.
    k_rsp_ready = 0;
    issue(1, 3'd3, 1'b0);
    k_cmd_valid = 1; k_cmd_write = 0; k_cmd_addr = 3'd7;
    c0 = rsp_cnt;
    repeat (2 + 5) step();
    check("t5_held_valid", rsp_valid, 1);
    check("t5_no_handoff", rsp_cnt - c0, 0);
    k_cmd_valid = 0;
    k_rsp_ready = 1;
    wait_done(5, "t5");
    check("t5_addr", obs_addr, 3);

    // 6: async reset during RD_WAIT discards the read.
    issue(0, 3'd5, 1'b0);
    step();
    step();
    @(posedge CLK);
    #2;
    RST   = 1;
    k_rst = 1;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) step();
    k_rst = 0;
    c0 = rsp_cnt;
    repeat (10) step();
    check("t6_no_rsp", rsp_cnt - c0, 0);
    issue(0, 3'd5, 1'b0);
    wait_done(20, "t6_after");
    check("t6_after_rdata", obs_rdata, 1);
    check("t6_after_err", obs_err, 0);

    // Randomized traffic with occasional long stalls to hit timeouts.
    stall = 0;
    for (int i = 0; i < 4000; i++) begin
      if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(10, 25);
      k_cmd_valid = ($urandom_range(0, 1) == 1);
      k_cmd_write = ($urandom_range(0, 1) == 1);
      k_cmd_addr  = ADDR_W'($urandom);
      k_cmd_wdata = DATA_W'($urandom);
      k_wrdy      = (stall == 0) && ($urandom_range(0, 9) < 7);
      k_rrdy      = (stall == 0) && ($urandom_range(0, 9) < 7);
      k_rsp_ready = ($urandom_range(0, 9) < 7);
      if (stall > 0) stall--;
      step();
    end
    k_cmd_valid = 0; k_wrdy = 1; k_rrdy = 1; k_rsp_ready = 1;
    repeat (40) step();
    check("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
